jesd204_rx_lane_sync_ctrl: RTL and testbench

JESD204_RX_LANE_SYNC_CTRL -- requirements
Module: jesd204_rx_lane_sync_ctrl

---
 rtl/jesd204_rx_lane_sync_ctrl_pkg.sv | 23 ++
 rtl/jesd204_rx_lane_sync_ctrl_if.sv | 27 ++
 rtl/jesd204_rx_sync_timer.sv | 36 +++
 rtl/jesd204_rx_lane_sync_ctrl.sv | 122 ++++++++++++
 tb/tb_jesd204_rx_lane_sync_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/jesd204_rx_lane_sync_ctrl_pkg.sv
// Shared jesd204 rx control definitions: FSM state encodings and reset hold length.
// Also used by the register map to decode status_state.
package jesd204_rx_lane_sync_ctrl_pkg;

    localparam logic [1:0] STATE_RESET = 2'd0;
    localparam logic [1:0] STATE_CGS   = 2'd1;
    localparam logic [1:0] STATE_ILAS  = 2'd2;
    localparam logic [1:0] STATE_DATA  = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET = STATE_RESET,
        ST_CGS   = STATE_CGS,
        ST_ILAS  = STATE_ILAS,
        ST_DATA  = STATE_DATA
    } sync_state_t;

    localparam int RESET_HOLD = 8;
    localparam int HOLD_W     = $clog2(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    localparam logic [7:0] RESTART_MAX = 8'hff;

endpackage

// File: rtl/jesd204_rx_lane_sync_ctrl_if.sv
// Lane-facing bundle between the sync controller and the jesd204_rx_lane instances.
// master = controller side, slave = lane side.
interface jesd204_rx_lane_sync_ctrl_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0] lane_cgs_ready;
    logic [NUM_LANES-1:0] lane_buffer_ready_n;
    logic [NUM_LANES-1:0] lane_cgs_reset;
    logic [NUM_LANES-1:0] lane_ifs_reset;
    logic                 buffer_release_n;

    modport master (
        input  lane_cgs_ready,
        input  lane_buffer_ready_n,
        output lane_cgs_reset,
        output lane_ifs_reset,
        output buffer_release_n
    );

    modport slave (
        output lane_cgs_ready,
        output lane_buffer_ready_n,
        input  lane_cgs_reset,
        input  lane_ifs_reset,
        input  buffer_release_n
    );
endinterface

// File: rtl/jesd204_rx_sync_timer.sv
// Masked all-ready reductions over enabled lanes plus the per-state timeout counter.
// expired fires on the edge at which the state has lasted cfg_timeout cycles.
module jesd204_rx_sync_timer #(
    parameter int NUM_LANES     = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LANES-1:0]     lanes_disable,
    input  logic [NUM_LANES-1:0]     cgs_ready,
    input  logic [NUM_LANES-1:0]     buffer_ready_n,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    input  logic                     count_en,
    input  logic                     clear,
    output logic                     all_cgs_ready,
    output logic                     all_buf_ready,
    output logic                     expired
);
    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH:0]   cnt_inc;

    assign all_cgs_ready = &(cgs_ready | lanes_disable);
    assign all_buf_ready = &(~buffer_ready_n | lanes_disable);

    assign cnt_inc = {1'b0, cnt_q} + (TIMEOUT_WIDTH+1)'(1);
    assign expired = count_en && (cfg_timeout != '0) &&
                     (cnt_inc == {1'b0, cfg_timeout});

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_inc[TIMEOUT_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/jesd204_rx_lane_sync_ctrl.sv
// Sequences the rx lanes through RESET -> CGS -> ILAS -> DATA and releases
// the elastic buffers together; all outputs are registered from next state.
module jesd204_rx_lane_sync_ctrl
    import jesd204_rx_lane_sync_ctrl_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LANES-1:0]     cfg_lanes_disable,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    jesd204_rx_lane_sync_ctrl_if.master lanes,
    output logic [1:0]               status_state,
    output logic                     status_timeout_err,
    output logic [7:0]               status_restart_cnt
);
    sync_state_t          state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [NUM_LANES-1:0] disable_q;
    logic [7:0]           restart_d;
    logic                 err_d;
    logic [NUM_LANES-1:0] cgs_reset_d, ifs_reset_d;
    logic                 release_n_d;
    logic                 all_cgs_ready, all_buf_ready, expired;
    logic                 cfg_changed, all_disabled;
    logic                 timeout_hit, cgs_drop;

    jesd204_rx_sync_timer #(
        .NUM_LANES     (NUM_LANES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .clk            (clk),
        .reset          (reset),
        .lanes_disable  (cfg_lanes_disable),
        .cgs_ready      (lanes.lane_cgs_ready),
        .buffer_ready_n (lanes.lane_buffer_ready_n),
        .cfg_timeout    (cfg_timeout),
        .count_en       (state_q == ST_CGS || state_q == ST_ILAS),
        .clear          (state_d != state_q),
        .all_cgs_ready  (all_cgs_ready),
        .all_buf_ready  (all_buf_ready),
        .expired        (expired)
    );

    assign cfg_changed  = (cfg_lanes_disable != disable_q);
    assign all_disabled = &cfg_lanes_disable;

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        cgs_drop    = 1'b0;
        unique case (state_q)
            ST_RESET: begin
                if (!all_disabled && hold_q == HOLD_LAST) state_d = ST_CGS;
            end
            ST_CGS: begin
                if (cfg_changed) state_d = ST_RESET;
                else if (all_cgs_ready) state_d = ST_ILAS;
                else if (expired) begin
                    state_d     = ST_RESET;
                    timeout_hit = 1'b1;
                end
            end
            ST_ILAS: begin
                if (cfg_changed) state_d = ST_RESET;
                else if (!all_cgs_ready) begin
                    state_d  = ST_RESET;
                    cgs_drop = 1'b1;
                end else if (all_buf_ready) state_d = ST_DATA;
                else if (expired) begin
                    state_d     = ST_RESET;
                    timeout_hit = 1'b1;
                end
            end
            ST_DATA: begin
                if (cfg_changed) state_d = ST_RESET;
                else if (!all_cgs_ready) begin
                    state_d  = ST_RESET;
                    cgs_drop = 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase

        hold_d = '0;
        if (state_q == ST_RESET && !all_disabled) hold_d = hold_q + HOLD_W'(1);

        err_d     = status_timeout_err | timeout_hit;
        restart_d = status_restart_cnt;
        if ((timeout_hit || cgs_drop) && status_restart_cnt != RESTART_MAX)
            restart_d = status_restart_cnt + 8'd1;

        cgs_reset_d = (state_d == ST_RESET) ? '1 : cfg_lanes_disable;
        ifs_reset_d = (state_d == ST_RESET || state_d == ST_CGS) ?
                      '1 : cfg_lanes_disable;
        release_n_d = (state_d != ST_DATA);
    end

    always_ff @(posedge clk) begin
        disable_q <= cfg_lanes_disable;
        if (reset) begin
            state_q                <= ST_RESET;
            hold_q                 <= '0;
            status_timeout_err     <= 1'b0;
            status_restart_cnt     <= '0;
            lanes.lane_cgs_reset   <= '1;
            lanes.lane_ifs_reset   <= '1;
            lanes.buffer_release_n <= 1'b1;
        end else begin
            state_q                <= state_d;
            hold_q                 <= hold_d;
            status_timeout_err     <= err_d;
            status_restart_cnt     <= restart_d;
            lanes.lane_cgs_reset   <= cgs_reset_d;
            lanes.lane_ifs_reset   <= ifs_reset_d;
            lanes.buffer_release_n <= release_n_d;
        end
    end

    assign status_state = state_q;
endmodule

// File: tb/tb_jesd204_rx_lane_sync_ctrl.sv
// Bench for jesd204_rx_lane_sync_ctrl: expectations are queued per cycle
// while stimulus is planned and popped when that cycle's outputs settle.
module tb_jesd204_rx_lane_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cfg_dis = '0;
    logic [15:0] cfg_to = '0;
    logic [1:0]  st;
    logic        terr;
    logic [7:0]  rcnt;

    jesd204_rx_lane_sync_ctrl_if #(.NUM_LANES(4)) lif();

    jesd204_rx_lane_sync_ctrl #(
        .NUM_LANES     (4),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_lanes_disable  (cfg_dis),
        .cfg_timeout        (cfg_to),
        .lanes              (lif.master),
        .status_state       (st),
        .status_timeout_err (terr),
        .status_restart_cnt (rcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam int S_STATE = 0;
    localparam int S_REL   = 1;
    localparam int S_ERR   = 2;
    localparam int S_RCNT  = 3;
    localparam int S_CGSR  = 4;
    localparam int S_IFSR  = 5;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            S_STATE: return int'(st);
            S_REL:   return int'(lif.buffer_release_n);
            S_ERR:   return int'(terr);
            S_RCNT:  return int'(rcnt);
            S_CGSR:  return int'(lif.lane_cgs_reset);
            default: return int'(lif.lane_ifs_reset);
        endcase
    endfunction

    task automatic exp_at(input int c, input int sel, input int val,
                          input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = val;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        chk("rst_state", obs(S_STATE), 0);
        chk("rst_rel", obs(S_REL), 1);
        chk("rst_err", obs(S_ERR), 0);
        chk("rst_rcnt", obs(S_RCNT), 0);
        chk("rst_cgsr", obs(S_CGSR), 15);
        chk("rst_ifsr", obs(S_IFSR), 15);
    endtask

    initial begin
        // nominal bring-up followed by a one-cycle cgs drop on lane 3
        cfg_dis = 4'b0000;
        cfg_to = 16'd0;
        lif.lane_cgs_ready = 4'b0000;
        lif.lane_buffer_ready_n = 4'b1111;
        do_reset();
        exp_at(7, S_STATE, 0, "hold7");
        exp_at(8, S_STATE, 1, "to_cgs");
        exp_at(8, S_CGSR, 0, "cgs_rel");
        exp_at(8, S_IFSR, 15, "ifs_in_cgs");
        exp_at(20, S_STATE, 1, "cgs_wait");
        exp_at(21, S_STATE, 2, "to_ilas");
        exp_at(21, S_IFSR, 0, "ifs_rel");
        exp_at(40, S_STATE, 2, "ilas_wait");
        exp_at(40, S_REL, 1, "rel_held");
        exp_at(41, S_STATE, 3, "to_data");
        exp_at(41, S_REL, 0, "rel_first");
        exp_at(50, S_REL, 0, "rel_stay");
        exp_at(51, S_STATE, 0, "resync_st");
        exp_at(51, S_REL, 1, "resync_rel");
        exp_at(51, S_RCNT, 1, "resync_cnt");
        exp_at(51, S_CGSR, 15, "resync_cgsr");
        exp_at(58, S_STATE, 0, "rehold");
        exp_at(59, S_STATE, 1, "re_cgs");
        exp_at(60, S_STATE, 2, "re_ilas");
        exp_at(61, S_STATE, 3, "re_data");
        exp_at(61, S_REL, 0, "re_rel");
        exp_at(61, S_RCNT, 1, "re_cnt");
        while (cyc < 62) begin
            tick();
            case (cyc)
                20: lif.lane_cgs_ready = 4'b1111;
                40: lif.lane_buffer_ready_n = 4'b0000;
                50: lif.lane_cgs_ready = 4'b0111;
                51: lif.lane_cgs_ready = 4'b1111;
                default: ;
            endcase
        end

        // staggered lanes, lane 2 masked, then a mask change in DATA
        cfg_dis = 4'b0100;
        lif.lane_cgs_ready = 4'b0000;
        lif.lane_buffer_ready_n = 4'b1111;
        do_reset();
        exp_at(8, S_STATE, 1, "stg_cgs");
        exp_at(8, S_CGSR, 4, "stg_cgsr8");
        exp_at(8, S_IFSR, 15, "stg_ifsr8");
        exp_at(25, S_STATE, 1, "stg_wait");
        exp_at(25, S_CGSR, 4, "stg_cgsr25");
        exp_at(26, S_STATE, 2, "stg_ilas");
        exp_at(26, S_CGSR, 4, "stg_cgsr26");
        exp_at(26, S_IFSR, 4, "stg_ifsr26");
        exp_at(30, S_STATE, 2, "stg_ilas30");
        exp_at(31, S_STATE, 3, "stg_data");
        exp_at(31, S_REL, 0, "stg_rel");
        exp_at(36, S_STATE, 0, "mask_chg");
        exp_at(36, S_RCNT, 0, "mask_norst");
        exp_at(36, S_CGSR, 15, "mask_cgsr");
        while (cyc < 37) begin
            tick();
            case (cyc)
                15: lif.lane_cgs_ready[0] = 1'b1;
                18: lif.lane_cgs_ready[1] = 1'b1;
                25: lif.lane_cgs_ready[3] = 1'b1;
                30: lif.lane_buffer_ready_n = 4'b0100;
                35: cfg_dis = 4'b0000;
                default: ;
            endcase
        end

        // timeouts, advance-beats-timeout, reset in ILAS, all lanes disabled
        cfg_dis = 4'b0000;
        cfg_to = 16'd100;
        lif.lane_cgs_ready = 4'b1101;
        lif.lane_buffer_ready_n = 4'b1111;
        do_reset();
        exp_at(8, S_STATE, 1, "to_cgs8");
        exp_at(107, S_STATE, 1, "to_pre");
        exp_at(107, S_ERR, 0, "to_err_pre");
        exp_at(108, S_STATE, 0, "to_fire");
        exp_at(108, S_ERR, 1, "to_err");
        exp_at(108, S_RCNT, 1, "to_cnt1");
        exp_at(115, S_STATE, 0, "to_hold");
        exp_at(116, S_STATE, 1, "to_retry");
        exp_at(116, S_ERR, 1, "to_sticky");
        exp_at(216, S_STATE, 0, "to_fire2");
        exp_at(216, S_RCNT, 2, "to_cnt2");
        exp_at(224, S_STATE, 1, "to_retry2");
        exp_at(324, S_STATE, 2, "adv_wins");
        exp_at(324, S_RCNT, 2, "adv_nocnt");
        exp_at(423, S_STATE, 2, "ilas_pre");
        exp_at(424, S_STATE, 0, "ilas_to");
        exp_at(424, S_RCNT, 3, "ilas_cnt");
        exp_at(433, S_STATE, 2, "ilas_again");
        exp_at(441, S_STATE, 0, "mid_rst_st");
        exp_at(441, S_REL, 1, "mid_rst_rel");
        exp_at(441, S_ERR, 0, "mid_rst_err");
        exp_at(441, S_RCNT, 0, "mid_rst_cnt");
        exp_at(441, S_CGSR, 15, "mid_rst_cgsr");
        exp_at(441, S_IFSR, 15, "mid_rst_ifsr");
        exp_at(448, S_STATE, 0, "post_hold");
        exp_at(449, S_STATE, 1, "post_cgs");
        exp_at(450, S_STATE, 2, "post_ilas");
        exp_at(461, S_STATE, 0, "alldis_st");
        exp_at(461, S_RCNT, 0, "alldis_cnt");
        exp_at(500, S_STATE, 0, "alldis_500");
        exp_at(600, S_STATE, 0, "alldis_600");
        exp_at(600, S_CGSR, 15, "alldis_cgsr");
        exp_at(607, S_STATE, 0, "reen_hold");
        exp_at(608, S_STATE, 1, "reen_cgs");
        exp_at(609, S_STATE, 2, "reen_ilas");
        while (cyc < 610) begin
            tick();
            case (cyc)
                323: lif.lane_cgs_ready = 4'b1111;
                440: reset = 1'b1;
                441: reset = 1'b0;
                460: cfg_dis = 4'b1111;
                600: cfg_dis = 4'b0000;
                default: ;
            endcase
        end

        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
